// File: rtl/sram_rr_arbiter_pkg.sv
// Package: sram_arb_pkg
// Purpose: shared width helpers, default configuration, the SRAM command
//          record and a one-hot to index encoder used by the round-robin
//          SRAM arbiter and its round-robin core.
// Contents:
//   calc_addr_width(num_words)  word address width, at least 1 bit
//   calc_be_width(data_width)   number of byte enables
//   calc_idx_width(num_ports)   port index width, at least 1 bit
//   sram_req_t                  {we, addr, wdata, be} at the default widths
//   onehot2idx(oh)              index of the set bit of a one-hot vector
package sram_arb_pkg;

    // Largest port count the one-hot encoder handles.
    localparam int unsigned MAX_PORTS = 32;
    localparam int unsigned IDX_MAX_W = 5;

    function automatic int unsigned calc_addr_width(input int unsigned num_words);
        return (num_words > 32'd1) ? $clog2(num_words) : 32'd1;
    endfunction

    function automatic int unsigned calc_be_width(input int unsigned data_width);
        return (data_width + 32'd7) / 32'd8;
    endfunction

    function automatic int unsigned calc_idx_width(input int unsigned num_ports);
        return (num_ports > 32'd1) ? $clog2(num_ports) : 32'd1;
    endfunction

    localparam int unsigned DEF_DATA_WIDTH = 32;
    localparam int unsigned DEF_NUM_WORDS  = 1024;
    localparam int unsigned DEF_ADDR_WIDTH = calc_addr_width(DEF_NUM_WORDS);
    localparam int unsigned DEF_BE_WIDTH   = calc_be_width(DEF_DATA_WIDTH);

    typedef struct packed {
        logic                      we;
        logic [DEF_ADDR_WIDTH-1:0] addr;
        logic [DEF_DATA_WIDTH-1:0] wdata;
        logic [DEF_BE_WIDTH-1:0]   be;
    } sram_req_t;

    // A zero vector encodes to 0; callers qualify with the OR of the vector.
    function automatic logic [IDX_MAX_W-1:0] onehot2idx(input logic [MAX_PORTS-1:0] oh);
        logic [IDX_MAX_W-1:0] idx;
        idx = {IDX_MAX_W{1'b0}};
        for (int i = 0; i < MAX_PORTS; i++) begin
            if (oh[i]) begin
                idx = IDX_MAX_W'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/sram_rr_arbiter_if.sv
// Interface: sram_rr_arbiter_if
// Purpose: bundles the requester-side handshake and the SRAM-side command
//          and read-data signals of the shared SRAM arbiter.
// Modports:
//   slave   arbiter view: takes req/we/addr/wdata/be and sram_rdata_i,
//           drives gnt/rvalid/rdata and the sram_* command
//   master  environment view (requesters plus SRAM macro)
// Packed per-port vectors keep port 0 in the LSBs.
interface sram_rr_arbiter_if
    import sram_arb_pkg::*;
#(
    parameter int unsigned NUM_PORTS  = 2,
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned NUM_WORDS  = DEF_NUM_WORDS
);
    localparam int unsigned ADDR_WIDTH = calc_addr_width(NUM_WORDS);
    localparam int unsigned BE_WIDTH   = calc_be_width(DATA_WIDTH);

    logic [NUM_PORTS-1:0]            req_i;
    logic [NUM_PORTS-1:0]            we_i;
    logic [NUM_PORTS*ADDR_WIDTH-1:0] addr_i;
    logic [NUM_PORTS*DATA_WIDTH-1:0] wdata_i;
    logic [NUM_PORTS*BE_WIDTH-1:0]   be_i;
    logic [NUM_PORTS-1:0]            gnt_o;
    logic [NUM_PORTS-1:0]            rvalid_o;
    logic [DATA_WIDTH-1:0]           rdata_o;

    logic                            sram_req_o;
    logic                            sram_we_o;
    logic [ADDR_WIDTH-1:0]           sram_addr_o;
    logic [DATA_WIDTH-1:0]           sram_wdata_o;
    logic [BE_WIDTH-1:0]             sram_be_o;
    logic [DATA_WIDTH-1:0]           sram_rdata_i;

    modport slave (
        input  req_i, we_i, addr_i, wdata_i, be_i, sram_rdata_i,
        output gnt_o, rvalid_o, rdata_o,
               sram_req_o, sram_we_o, sram_addr_o, sram_wdata_o, sram_be_o
    );

    modport master (
        output req_i, we_i, addr_i, wdata_i, be_i, sram_rdata_i,
        input  gnt_o, rvalid_o, rdata_o,
               sram_req_o, sram_we_o, sram_addr_o, sram_wdata_o, sram_be_o
    );

endinterface

// File: rtl/sram_rr_arbiter_rr.sv
// Module: rr_arbiter
// Purpose: generic round-robin arbiter with a rotating priority pointer,
//          reusable in front of any shared single-issue slave.
// Ports:
//   clk_i      clock
//   rst_i      synchronous active-high reset, returns the pointer to 0
//   req_i      per-requester request
//   advance_i  a grant this cycle is taken; moves the pointer past the winner
//   gnt_o      one-hot grant, combinational from req_i and the pointer
module rr_arbiter
    import sram_arb_pkg::*;
#(
    parameter int unsigned NUM_PORTS = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [NUM_PORTS-1:0] req_i,
    input  logic                 advance_i,
    output logic [NUM_PORTS-1:0] gnt_o
);
    localparam int unsigned IDX_W = calc_idx_width(NUM_PORTS);

    logic [IDX_W-1:0]     ptr_r;
    logic [IDX_W-1:0]     ptr_nxt_s;
    logic [IDX_W-1:0]     winner_s;
    logic                 found_s;
    logic [NUM_PORTS-1:0] gnt_s;

    // Search ptr, ptr+1, ... (mod NUM_PORTS); first requester found wins.
    always_comb begin
        int unsigned idx;
        idx      = 32'd0;
        found_s  = 1'b0;
        winner_s = ptr_r;
        gnt_s    = {NUM_PORTS{1'b0}};
        for (int unsigned k = 0; k < NUM_PORTS; k++) begin
            idx = (32'(ptr_r) + k) % NUM_PORTS;
            if (!found_s && req_i[idx]) begin
                found_s  = 1'b1;
                winner_s = IDX_W'(idx);
            end else begin
                found_s  = found_s;
            end
        end
        if (found_s) begin
            gnt_s[winner_s] = 1'b1;
        end else begin
            gnt_s = {NUM_PORTS{1'b0}};
        end
    end

    // Next pointer: one past the winner, wrapping; hold when idle.
    always_comb begin
        ptr_nxt_s = ptr_r;
        if (advance_i && found_s) begin
            if (winner_s == IDX_W'(NUM_PORTS - 1)) begin
                ptr_nxt_s = {IDX_W{1'b0}};
            end else begin
                ptr_nxt_s = winner_s + IDX_W'(1);
            end
        end else begin
            ptr_nxt_s = ptr_r;
        end
    end

    // Priority pointer register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_r <= {IDX_W{1'b0}};
        end else begin
            ptr_r <= ptr_nxt_s;
        end
    end

    assign gnt_o = gnt_s;

endmodule

// File: rtl/sram_rr_arbiter.sv
// Module: sram_rr_arbiter
// Purpose: shares one single-port SRAM (1-cycle read latency) between
//          NUM_PORTS requesters with round-robin fairness and routes each
//          response back to the port that issued it.
// Ports:
//   clk_i   clock
//   rst_i   synchronous active-high reset; drops any response in flight
//   bus     sram_rr_arbiter_if.slave: per-port req/we/addr/wdata/be in,
//           one-hot gnt (combinational) and rvalid out, shared rdata out,
//           sram_req/we/addr/wdata/be out, sram_rdata in
module sram_rr_arbiter
    import sram_arb_pkg::*;
#(
    parameter int unsigned NUM_PORTS  = 2,
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned NUM_WORDS  = DEF_NUM_WORDS
) (
    input  logic             clk_i,
    input  logic             rst_i,
    sram_rr_arbiter_if.slave bus
);
    localparam int unsigned ADDR_WIDTH = calc_addr_width(NUM_WORDS);
    localparam int unsigned BE_WIDTH   = calc_be_width(DATA_WIDTH);
    localparam int unsigned IDX_W      = calc_idx_width(NUM_PORTS);

    // Same layout as sram_req_t, sized by this instance's parameters.
    typedef struct packed {
        logic                  we;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] wdata;
        logic [BE_WIDTH-1:0]   be;
    } cmd_t;

    logic [NUM_PORTS-1:0] arb_gnt_s;
    logic [NUM_PORTS-1:0] gnt_s;
    logic                 grant_any_s;
    logic [IDX_W-1:0]     win_idx_s;
    logic [IDX_W-1:0]     sel_idx_s;
    logic [IDX_W-1:0]     sel_idx_r;
    cmd_t                 cmd_s;
    logic                 rsp_valid_r;
    logic [IDX_W-1:0]     rsp_idx_r;
    logic                 rsp_read_r;
    logic [NUM_PORTS-1:0] rvalid_s;

    // Every grant given outside reset is accepted, so the pointer advances
    // whenever the arbiter finds a winner.
    rr_arbiter #(
        .NUM_PORTS (NUM_PORTS)
    ) u_rr_arbiter (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .req_i     (bus.req_i),
        .advance_i (~rst_i),
        .gnt_o     (arb_gnt_s)
    );

    // Grant gating during reset and winner index encoding.
    always_comb begin
        if (rst_i) begin
            gnt_s = {NUM_PORTS{1'b0}};
        end else begin
            gnt_s = arb_gnt_s;
        end
        grant_any_s = |gnt_s;
        win_idx_s   = IDX_W'(onehot2idx(MAX_PORTS'(gnt_s)));
    end

    // Command mux select: the current winner, else the last winner.
    always_comb begin
        if (grant_any_s) begin
            sel_idx_s = win_idx_s;
        end else begin
            sel_idx_s = sel_idx_r;
        end
    end

    // Command mux: pick the selected port's slice of each packed bus.
    always_comb begin
        cmd_s.we    = bus.we_i[sel_idx_s];
        cmd_s.addr  = bus.addr_i[32'(sel_idx_s) * ADDR_WIDTH +: ADDR_WIDTH];
        cmd_s.wdata = bus.wdata_i[32'(sel_idx_s) * DATA_WIDTH +: DATA_WIDTH];
        cmd_s.be    = bus.be_i[32'(sel_idx_s) * BE_WIDTH +: BE_WIDTH];
    end

    // SRAM command outputs; everything is held low in reset and the write
    // strobe is qualified by a grant so an idle cycle never writes.
    always_comb begin
        if (rst_i) begin
            bus.sram_req_o   = 1'b0;
            bus.sram_we_o    = 1'b0;
            bus.sram_addr_o  = {ADDR_WIDTH{1'b0}};
            bus.sram_wdata_o = {DATA_WIDTH{1'b0}};
            bus.sram_be_o    = {BE_WIDTH{1'b0}};
        end else begin
            bus.sram_req_o   = grant_any_s;
            bus.sram_we_o    = grant_any_s & cmd_s.we;
            bus.sram_addr_o  = cmd_s.addr;
            bus.sram_wdata_o = cmd_s.wdata;
            bus.sram_be_o    = cmd_s.be;
        end
        bus.gnt_o = gnt_s;
    end

    // Last-winner register feeding the idle mux select.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sel_idx_r <= {IDX_W{1'b0}};
        end else begin
            sel_idx_r <= sel_idx_s;
        end
    end

    // Response register: which port was granted and whether it read.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rsp_valid_r <= 1'b0;
            rsp_idx_r   <= {IDX_W{1'b0}};
            rsp_read_r  <= 1'b0;
        end else begin
            rsp_valid_r <= grant_any_s;
            rsp_idx_r   <= win_idx_s;
            rsp_read_r  <= grant_any_s & ~cmd_s.we;
        end
    end

    // Response decode. The rst_i term drops a response registered in the
    // cycle before reset rose, so it never reaches the requester.
    always_comb begin
        rvalid_s = {NUM_PORTS{1'b0}};
        if (rsp_valid_r && !rst_i) begin
            rvalid_s[rsp_idx_r] = 1'b1;
        end else begin
            rvalid_s = {NUM_PORTS{1'b0}};
        end
        bus.rvalid_o = rvalid_s;
        if (rsp_valid_r && rsp_read_r && !rst_i) begin
            bus.rdata_o = bus.sram_rdata_i;
        end else begin
            bus.rdata_o = {DATA_WIDTH{1'b0}};
        end
    end

endmodule

// File: tb/tb_sram_rr_arbiter.sv
// Testbench: tb_sram_rr_arbiter
// Purpose: scoreboard bench for sram_rr_arbiter with two ports and a
//          behavioural single-port SRAM (1-cycle read data).
module tb_sram_rr_arbiter;
    localparam int NP = 2;
    localparam int DW = 32;
    localparam int NW = 1024;
    localparam int AW = 10;
    localparam int BW = 4;

    typedef struct packed {
        logic [NP-1:0] rvalid;
        logic [DW-1:0] rdata;
    } rsp_t;

    logic clk_i;
    logic rst_i;

    sram_rr_arbiter_if #(.NUM_PORTS(NP), .DATA_WIDTH(DW), .NUM_WORDS(NW)) bif ();

    sram_rr_arbiter #(.NUM_PORTS(NP), .DATA_WIDTH(DW), .NUM_WORDS(NW)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bif)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Behavioural SRAM macro; its contents clear while rst_i is high.
    logic [DW-1:0] mem [NW];
    always @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < NW; i++) mem[i] <= '0;
            bif.sram_rdata_i <= '0;
        end else if (bif.sram_req_o) begin
            if (bif.sram_we_o) begin
                for (int b = 0; b < BW; b++) begin
                    if (bif.sram_be_o[b]) mem[bif.sram_addr_o][b*8 +: 8] <= bif.sram_wdata_o[b*8 +: 8];
                end
            end else begin
                bif.sram_rdata_i <= mem[bif.sram_addr_o];
            end
        end
    end

    // Bench-side reference: memory image, pointer and pending commands.
    logic [DW-1:0] ref_mem [NW];
    int            mdl_ptr;
    logic          pend_v     [NP];
    logic          pend_we    [NP];
    logic [AW-1:0] pend_addr  [NP];
    logic [DW-1:0] pend_wdata [NP];
    logic [BW-1:0] pend_be    [NP];
    rsp_t          sb_q [$];

    int            n_checks;
    int            n_errors;
    int            gnt_cnt [NP];
    logic [NP-1:0] last_gnt;
    logic [NP-1:0] last_rvalid;
    logic [DW-1:0] last_rdata;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic set_cmd(input int p, input logic we, input logic [AW-1:0] a,
                           input logic [DW-1:0] d, input logic [BW-1:0] be);
        pend_v[p]     = 1'b1;
        pend_we[p]    = we;
        pend_addr[p]  = a;
        pend_wdata[p] = d;
        pend_be[p]    = be;
    endtask

    // One clock cycle: drive, predict/compare at negedge, advance model.
    task automatic tick();
        int            win;
        int            idx;
        logic [NP-1:0] exp_gnt;
        rsp_t          exp_rsp;
        rsp_t          new_rsp;
        for (int p = 0; p < NP; p++) begin
            bif.req_i[p]                = pend_v[p];
            bif.we_i[p]                 = pend_we[p];
            bif.addr_i[p*AW +: AW]      = pend_addr[p];
            bif.wdata_i[p*DW +: DW]     = pend_wdata[p];
            bif.be_i[p*BW +: BW]        = pend_be[p];
        end
        @(negedge clk_i);
        win = -1;
        if (!rst_i) begin
            for (int k = 0; k < NP; k++) begin
                idx = (mdl_ptr + k) % NP;
                if (win < 0 && pend_v[idx]) win = idx;
            end
        end
        exp_gnt = '0;
        if (win >= 0) exp_gnt[win] = 1'b1;
        check_eq("gnt", 64'(bif.gnt_o), 64'(exp_gnt));
        check_eq("sram_req", 64'(bif.sram_req_o), 64'(win >= 0));
        check_eq("sram_we", 64'(bif.sram_we_o), 64'(win >= 0 && pend_we[win]));
        if (win >= 0) begin
            check_eq("sram_addr", 64'(bif.sram_addr_o), 64'(pend_addr[win]));
            if (pend_we[win]) begin
                check_eq("sram_wdata", 64'(bif.sram_wdata_o), 64'(pend_wdata[win]));
                check_eq("sram_be", 64'(bif.sram_be_o), 64'(pend_be[win]));
            end
        end else if (rst_i) begin
            check_eq("rst_sram_addr", 64'(bif.sram_addr_o), 64'd0);
            check_eq("rst_sram_be", 64'(bif.sram_be_o), 64'd0);
        end
        if (sb_q.size() > 0) exp_rsp = sb_q.pop_front();
        else exp_rsp = '0;
        if (rst_i) exp_rsp = '0;
        check_eq("rvalid", 64'(bif.rvalid_o), 64'(exp_rsp.rvalid));
        check_eq("rdata", 64'(bif.rdata_o), 64'(exp_rsp.rdata));
        last_gnt    = bif.gnt_o;
        last_rvalid = bif.rvalid_o;
        last_rdata  = bif.rdata_o;
        for (int p = 0; p < NP; p++) gnt_cnt[p] += int'(bif.gnt_o[p]);
        new_rsp = '0;
        if (win >= 0) begin
            new_rsp.rvalid = exp_gnt;
            if (pend_we[win]) begin
                for (int b = 0; b < BW; b++) begin
                    if (pend_be[win][b]) ref_mem[pend_addr[win]][b*8 +: 8] = pend_wdata[win][b*8 +: 8];
                end
            end else begin
                new_rsp.rdata = ref_mem[pend_addr[win]];
            end
        end
        sb_q.push_back(new_rsp);
        @(posedge clk_i);
        #1;
        if (rst_i) begin
            mdl_ptr = 0;
            for (int i = 0; i < NW; i++) ref_mem[i] = '0;
        end else if (win >= 0) begin
            mdl_ptr     = (win + 1) % NP;
            pend_v[win] = 1'b0;
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        mdl_ptr  = 0;
        for (int p = 0; p < NP; p++) begin
            gnt_cnt[p] = 0;
            set_cmd(p, 1'b0, '0, '0, '0);
        end
        for (int i = 0; i < NW; i++) ref_mem[i] = '0;

        // Reset for 3 cycles with both ports requesting.
        rst_i = 1'b1;
        repeat (3) tick();
        rst_i = 1'b0;
        tick();
        check_eq("first_gnt_port0", 64'(last_gnt), 64'd1);
        tick();
        tick();

        // Port 1 writes then reads back address 5.
        set_cmd(1, 1'b1, 10'd5, 32'hDEADBEEF, 4'hF);
        tick();
        set_cmd(1, 1'b0, 10'd5, '0, '0);
        tick();
        check_eq("wr_rvalid_p1", 64'(last_rvalid), 64'd2);
        tick();
        check_eq("rd_rvalid_p1", 64'(last_rvalid), 64'd2);
        check_eq("rd_deadbeef", 64'(last_rdata), 64'hDEADBEEF);

        // Both ports request every cycle for 8 cycles.
        for (int p = 0; p < NP; p++) gnt_cnt[p] = 0;
        for (int i = 0; i < 8; i++) begin
            if (!pend_v[0]) set_cmd(0, 1'b1, AW'(16 + i), 32'h100 + DW'(i), 4'hF);
            if (!pend_v[1]) set_cmd(1, 1'b0, AW'(16 + i), '0, '0);
            tick();
        end
        pend_v[0] = 1'b0;
        pend_v[1] = 1'b0;
        check_eq("rr_cnt_p0", 64'(gnt_cnt[0]), 64'd4);
        check_eq("rr_cnt_p1", 64'(gnt_cnt[1]), 64'd4);
        tick();

        // Partial write merge on address 9.
        set_cmd(0, 1'b1, 10'd9, 32'h11223344, 4'hF);
        tick();
        set_cmd(0, 1'b1, 10'd9, 32'hAABBCCDD, 4'b0010);
        tick();
        set_cmd(0, 1'b0, 10'd9, '0, '0);
        tick();
        tick();
        check_eq("partial_wr", 64'(last_rdata), 64'h1122CC44);

        // Read then write the same address back to back, then read again.
        set_cmd(1, 1'b1, 10'd3, 32'hA5, 4'hF);
        tick();
        tick();
        set_cmd(0, 1'b0, 10'd3, '0, '0);
        tick();
        set_cmd(1, 1'b1, 10'd3, 32'h5, 4'hF);
        tick();
        check_eq("rd_before_wr", 64'(last_rdata), 64'hA5);
        set_cmd(0, 1'b0, 10'd3, '0, '0);
        tick();
        tick();
        check_eq("rd_after_wr", 64'(last_rdata), 64'h5);

        // Reset pulse in the cycle after a read grant.
        set_cmd(0, 1'b0, 10'd3, '0, '0);
        tick();
        rst_i = 1'b1;
        tick();
        check_eq("rst_drop_rvalid", 64'(last_rvalid), 64'd0);
        rst_i = 1'b0;
        set_cmd(0, 1'b0, 10'd0, '0, '0);
        set_cmd(1, 1'b0, 10'd1, '0, '0);
        tick();
        check_eq("post_rst_gnt_p0", 64'(last_gnt), 64'd1);
        tick();
        tick();
        tick();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
